// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - opcodes, sequencer state encoding and opcode class helpers
package risc_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALTED    = 2'd1,
        ST_STEP_WAIT = 2'd2,
        ST_MEM_WAIT  = 2'd3
    } state_t;

    // Opcodes that read an operand from memory and load the accumulator.
    function automatic logic op_uses_acc(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

    function automatic logic op_is_store(input logic [2:0] op);
        return (op == OP_STO);
    endfunction

endpackage

// File: rtl/risc_sequencer_if.sv
// rtl/risc_sequencer_if.sv - opcode/handshake inputs and datapath controls of the sequencer
interface risc_sequencer_if;

    logic [2:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       run;
    logic       step;
    logic       step_mode;

    logic       sel;
    logic       rd;
    logic       ld_ir;
    logic       halt;
    logic       inc_pc;
    logic       ld_ac;
    logic       wr;
    logic       ld_pc;
    logic       data_e;
    logic [2:0] phase;
    logic [1:0] state;
    logic       timeout_err;

    modport slave (
        input  opcode, zero, mem_ready, run, step, step_mode,
        output sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e,
        output phase, state, timeout_err
    );

    modport master (
        output opcode, zero, mem_ready, run, step, step_mode,
        input  sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e,
        input  phase, state, timeout_err
    );

endinterface

// File: rtl/risc_decode.sv
// rtl/risc_decode.sv - combinational control decode from phase, opcode, zero flag and state
module risc_decode
    import risc_pkg::*;
(
    input  logic [2:0] i_phase,
    input  logic [2:0] i_opcode,
    input  logic       i_zero,
    input  state_t     i_state,
    output logic       o_sel,
    output logic       o_rd,
    output logic       o_ld_ir,
    output logic       o_halt,
    output logic       o_inc_pc,
    output logic       o_ld_ac,
    output logic       o_wr,
    output logic       o_ld_pc,
    output logic       o_data_e
);

    logic w_h;
    logic w_z;
    logic w_a;
    logic w_s;
    logic w_j;

    assign w_h = (i_opcode == OP_HLT);
    assign w_z = (i_opcode == OP_SKZ) && i_zero;
    assign w_a = op_uses_acc(i_opcode);
    assign w_s = op_is_store(i_opcode);
    assign w_j = (i_opcode == OP_JMP);

    always_comb begin
        o_sel    = 1'b0;
        o_rd     = 1'b0;
        o_ld_ir  = 1'b0;
        o_halt   = 1'b0;
        o_inc_pc = 1'b0;
        o_ld_ac  = 1'b0;
        o_wr     = 1'b0;
        o_ld_pc  = 1'b0;
        o_data_e = 1'b0;
        case (i_state)
            ST_HALTED: begin
                o_sel  = 1'b1;
                o_halt = 1'b1;
            end
            ST_STEP_WAIT: begin
                o_sel = 1'b1;
            end
            default: begin
                // MEM_WAIT decodes exactly like RUN so a stalled phase keeps its controls.
                case (i_phase)
                    3'd0: begin
                        o_sel = 1'b1;
                    end
                    3'd1: begin
                        o_sel = 1'b1;
                        o_rd  = 1'b1;
                    end
                    3'd2, 3'd3: begin
                        o_sel   = 1'b1;
                        o_rd    = 1'b1;
                        o_ld_ir = 1'b1;
                    end
                    3'd4: begin
                        o_halt   = w_h;
                        o_inc_pc = 1'b1;
                    end
                    3'd5: begin
                        o_rd = w_a;
                    end
                    3'd6: begin
                        o_rd     = w_a;
                        o_inc_pc = w_z;
                        o_ld_pc  = w_j;
                        o_data_e = w_s;
                    end
                    default: begin
                        o_rd     = w_a;
                        o_ld_ac  = w_a;
                        o_ld_pc  = w_j;
                        o_wr     = w_s;
                        o_data_e = w_s;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/risc_sequencer.sv
// rtl/risc_sequencer.sv - eight-phase instruction sequencer with memory stalls, halt and single-step
module risc_sequencer
    import risc_pkg::*;
#(
    parameter int WAIT_EN = 1,
    parameter int STEP_EN = 1,
    parameter int WAIT_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    risc_sequencer_if.slave bus
);

    localparam logic [WAIT_W-1:0] STALL_LAST = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] STALL_ONE  = WAIT_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_phase;
    logic [2:0]        w_phase_nxt;
    logic [WAIT_W-1:0] r_stall_cnt;
    logic [WAIT_W-1:0] w_stall_cnt_nxt;
    logic [WAIT_W-1:0] w_stall_inc;
    logic              r_timeout_err;
    logic              w_timeout_nxt;

    logic w_step_mode;
    logic w_mem_busy;
    logic w_wait_pt;
    logic w_hlt;
    logic w_step_stop;

    assign w_step_mode = (STEP_EN != 0) ? bus.step_mode : 1'b0;
    assign w_mem_busy  = (WAIT_EN != 0) ? !bus.mem_ready : 1'b0;
    assign w_hlt       = (bus.opcode == OP_HLT);
    assign w_wait_pt   = (r_phase == 3'd3) ||
                         ((r_phase == 3'd7) && (op_uses_acc(bus.opcode) || op_is_store(bus.opcode)));
    assign w_step_stop = (r_phase == 3'd7) && w_step_mode;
    assign w_stall_inc = r_stall_cnt + STALL_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_phase       <= 3'd0;
            r_stall_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_phase       <= w_phase_nxt;
            r_stall_cnt   <= w_stall_cnt_nxt;
            r_timeout_err <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_stall_cnt_nxt = r_stall_cnt;
        w_timeout_nxt   = r_timeout_err;
        case (r_state)
            ST_RUN: begin
                if (w_wait_pt && w_mem_busy) begin
                    w_state_nxt = ST_MEM_WAIT;
                end else if ((r_phase == 3'd4) && w_hlt) begin
                    // Phase 4 has already pulsed inc_pc, so the PC is left past the HLT.
                    w_state_nxt = ST_HALTED;
                    w_phase_nxt = 3'd0;
                end else if (w_step_stop) begin
                    w_state_nxt = ST_STEP_WAIT;
                    w_phase_nxt = 3'd0;
                end else begin
                    w_phase_nxt = r_phase + 3'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (w_mem_busy) begin
                    if (w_stall_inc == STALL_LAST) begin
                        w_timeout_nxt   = 1'b1;
                        w_state_nxt     = ST_HALTED;
                        w_phase_nxt     = 3'd0;
                        w_stall_cnt_nxt = '0;
                    end else begin
                        w_stall_cnt_nxt = w_stall_inc;
                    end
                end else begin
                    w_stall_cnt_nxt = '0;
                    if (w_step_stop) begin
                        w_state_nxt = ST_STEP_WAIT;
                        w_phase_nxt = 3'd0;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_phase_nxt = r_phase + 3'd1;
                    end
                end
            end
            ST_HALTED: begin
                if (bus.run) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                // Leaving STEP_WAIT always needs a pulse, even once step_mode has dropped.
                if (bus.run || bus.step) begin
                    w_state_nxt = ST_RUN;
                end
            end
        endcase
    end

    assign bus.phase       = r_phase;
    assign bus.state       = r_state;
    assign bus.timeout_err = r_timeout_err;

    risc_decode u_decode (
        .i_phase  (r_phase),
        .i_opcode (bus.opcode),
        .i_zero   (bus.zero),
        .i_state  (r_state),
        .o_sel    (bus.sel),
        .o_rd     (bus.rd),
        .o_ld_ir  (bus.ld_ir),
        .o_halt   (bus.halt),
        .o_inc_pc (bus.inc_pc),
        .o_ld_ac  (bus.ld_ac),
        .o_wr     (bus.wr),
        .o_ld_pc  (bus.ld_pc),
        .o_data_e (bus.data_e)
    );

endmodule

// File: tb/tb_risc_sequencer.sv
// tb/tb_risc_sequencer.sv - instruction vectors, stalls, halt, step and reset checks for risc_sequencer
module tb_risc_sequencer;

    localparam logic [1:0] S_RUN       = 2'd0;
    localparam logic [1:0] S_HALTED    = 2'd1;
    localparam logic [1:0] S_STEP_WAIT = 2'd2;
    localparam logic [1:0] S_MEM_WAIT  = 2'd3;

    // control word order: sel rd ld_ir halt inc_pc ld_ac wr ld_pc data_e
    localparam logic [8:0] C_SEL   = 9'h100;
    localparam logic [8:0] C_HALT  = 9'h020;
    localparam logic [8:0] C_LDPC  = 9'h002;
    localparam logic [8:0] C_FETCH = 9'h1C0;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic       zero;
        logic       wp7;
        int         st3;
        int         st7;
        int         nph;
        logic [7:0] rd, halt, inc, ldac, wr, ldpc, de;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic [14:0] sb[$];
    vec_t vecs[$];
    vec_t hlt_v;
    vec_t jmp_v;
    logic [7:0] m_sel  = 8'h0F;
    logic [7:0] m_ldir = 8'h0C;

    risc_sequencer_if bus ();

    risc_sequencer #(
        .WAIT_EN (1),
        .STEP_EN (1),
        .WAIT_W  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mkv(input string name, input logic [2:0] op, input logic zero,
                                 input logic wp7, input int st3, input int st7, input int nph,
                                 input logic [7:0] rd, input logic [7:0] halt, input logic [7:0] inc,
                                 input logic [7:0] ldac, input logic [7:0] wr, input logic [7:0] ldpc,
                                 input logic [7:0] de);
        vec_t v;
        v.name = name; v.op = op; v.zero = zero; v.wp7 = wp7;
        v.st3 = st3; v.st7 = st7; v.nph = nph;
        v.rd = rd; v.halt = halt; v.inc = inc; v.ldac = ldac; v.wr = wr; v.ldpc = ldpc; v.de = de;
        return v;
    endfunction

    function automatic logic [14:0] mk_exp(input logic [2:0] ph, input logic [1:0] st,
                                           input logic tmo, input logic [8:0] c);
        return {ph, st, tmo, c};
    endfunction

    function automatic logic [14:0] act_word();
        return {bus.phase, bus.state, bus.timeout_err, bus.sel, bus.rd, bus.ld_ir, bus.halt,
                bus.inc_pc, bus.ld_ac, bus.wr, bus.ld_pc, bus.data_e};
    endfunction

    function automatic logic [8:0] row_ctrl(input vec_t v, input int p);
        logic [2:0] i;
        i = p[2:0];
        return {m_sel[i], v.rd[i], m_ldir[i], v.halt[i], v.inc[i], v.ldac[i], v.wr[i], v.ldpc[i], v.de[i]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name);
        logic [14:0] exp;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: actual %h required a queued expectation", name, act_word());
        end else begin
            exp = sb.pop_front();
            check(name, 32'(act_word()), 32'(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered one step after a rising edge with phase 0 current; returns likewise after the last phase.
    task automatic run_instr(input vec_t v);
        bus.opcode = v.op;
        bus.zero   = v.zero;
        for (int p = 0; p < v.nph; p++) begin
            logic wp;
            int   n;
            wp = (p == 3) || ((p == 7) && v.wp7);
            n  = (p == 3) ? v.st3 : ((p == 7) ? v.st7 : 0);
            for (int s = 0; s <= n; s++) begin
                bus.mem_ready = wp && (s == n);
                sb.push_back(mk_exp(3'(p), (s == 0) ? S_RUN : S_MEM_WAIT, 1'b0, row_ctrl(v, p)));
                #1;
                check_out($sformatf("%s_p%0d_s%0d", v.name, p, s));
                tick();
            end
        end
    endtask

    initial begin
        int n;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.opcode = 3'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        bus.run = 1'b0; bus.step = 1'b0; bus.step_mode = 1'b0;

        //          name        op    z     wp7   st3 st7 nph rd     halt   inc    ldac   wr     ldpc   de
        vecs.push_back(mkv("add",      3'd2, 1'b0, 1'b1, 0, 0, 8, 8'hEE, 8'h00, 8'h10, 8'h80, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mkv("and_st3",  3'd3, 1'b1, 1'b1, 2, 0, 8, 8'hEE, 8'h00, 8'h10, 8'h80, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mkv("xor",      3'd4, 1'b0, 1'b1, 0, 0, 8, 8'hEE, 8'h00, 8'h10, 8'h80, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mkv("lda_st7",  3'd5, 1'b0, 1'b1, 0, 2, 8, 8'hEE, 8'h00, 8'h10, 8'h80, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mkv("sto_st7",  3'd6, 1'b0, 1'b1, 0, 3, 8, 8'h0E, 8'h00, 8'h10, 8'h00, 8'h80, 8'h00, 8'hC0));
        vecs.push_back(mkv("sto_st3",  3'd6, 1'b1, 1'b1, 1, 0, 8, 8'h0E, 8'h00, 8'h10, 8'h00, 8'h80, 8'h00, 8'hC0));
        vecs.push_back(mkv("jmp",      3'd7, 1'b0, 1'b0, 0, 0, 8, 8'h0E, 8'h00, 8'h10, 8'h00, 8'h00, 8'hC0, 8'h00));
        vecs.push_back(mkv("skz_z1",   3'd1, 1'b1, 1'b0, 0, 0, 8, 8'h0E, 8'h00, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mkv("skz_z0",   3'd1, 1'b0, 1'b0, 0, 0, 8, 8'h0E, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mkv("add_both", 3'd2, 1'b0, 1'b1, 1, 1, 8, 8'hEE, 8'h00, 8'h10, 8'h80, 8'h00, 8'h00, 8'h00));
        hlt_v = mkv("hlt", 3'd0, 1'b0, 1'b0, 0, 0, 5, 8'h0E, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00);
        jmp_v = vecs[6];

        tick();
        check("reset_state", 32'(act_word()), 32'(mk_exp(3'd0, S_RUN, 1'b0, C_SEL)));
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_instr(vecs[i]);
        end

        run_instr(hlt_v);
        check("halted", 32'(act_word()), 32'(mk_exp(3'd0, S_HALTED, 1'b0, C_SEL | C_HALT)));
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        check("halted_step_ignored", 32'(act_word()), 32'(mk_exp(3'd0, S_HALTED, 1'b0, C_SEL | C_HALT)));
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        check("run_resume", 32'(act_word()), 32'(mk_exp(3'd0, S_RUN, 1'b0, C_SEL)));

        bus.step_mode = 1'b1;
        run_instr(jmp_v);
        check("step_wait_1", 32'(act_word()), 32'(mk_exp(3'd0, S_STEP_WAIT, 1'b0, C_SEL)));
        tick();
        tick();
        check("step_wait_hold", 32'(act_word()), 32'(mk_exp(3'd0, S_STEP_WAIT, 1'b0, C_SEL)));
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        run_instr(jmp_v);
        check("step_wait_2", 32'(act_word()), 32'(mk_exp(3'd0, S_STEP_WAIT, 1'b0, C_SEL)));
        bus.step_mode = 1'b0;
        tick();
        tick();
        check("step_mode_off_hold", 32'(act_word()), 32'(mk_exp(3'd0, S_STEP_WAIT, 1'b0, C_SEL)));
        bus.run = 1'b1;
        bus.step = 1'b1;
        tick();
        bus.run = 1'b0;
        bus.step = 1'b0;
        run_instr(jmp_v);

        bus.opcode = 3'd2;
        bus.mem_ready = 1'b1;
        tick(); tick(); tick();
        bus.mem_ready = 1'b0;
        tick();
        check("stall_hold_p3", 32'(act_word()), 32'(mk_exp(3'd3, S_MEM_WAIT, 1'b0, C_FETCH)));
        n = 0;
        while (bus.state == S_MEM_WAIT && n < 40) begin
            n++;
            tick();
        end
        check("timeout_stall_cycles", 32'(n), 32'd15);
        check("timeout_halted", 32'(act_word()), 32'(mk_exp(3'd0, S_HALTED, 1'b1, C_SEL | C_HALT)));
        bus.mem_ready = 1'b1;
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        check("timeout_sticky", 32'(act_word()), 32'(mk_exp(3'd0, S_RUN, 1'b1, C_SEL)));
        #2 rst = 1'b1;
        #1;
        check("timeout_cleared", 32'(act_word()), 32'(mk_exp(3'd0, S_RUN, 1'b0, C_SEL)));
        tick();
        rst = 1'b0;

        bus.opcode = 3'd7;
        for (int i = 0; i < 6; i++) tick();
        check("jmp_p6", 32'(act_word()), 32'(mk_exp(3'd6, S_RUN, 1'b0, C_LDPC)));
        #1 rst = 1'b1;
        #1;
        check("rst_async_p6", 32'(act_word()), 32'(mk_exp(3'd0, S_RUN, 1'b0, C_SEL)));
        tick();
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/risc_sequencer.md
RISC_SEQUENCER -- requirements
Module: risc_sequencer

Interface
REQ-001 SHALL have parameter WAIT_EN, default 1, meaning 1 enables mem_ready stalls and 0 ignores mem_ready.
REQ-002 SHALL have parameter STEP_EN, default 1, meaning 1 enables single-step mode and 0 ties step_mode low internally.
REQ-003 SHALL have parameter WAIT_W, default 4, meaning width of the stall/timeout counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port opcode, input, 3 bits: instruction opcode (HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7).
REQ-007 SHALL have port zero, input, 1 bit: accumulator-zero flag.
REQ-008 SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-009 SHALL have ports run, step and step_mode, each input, 1 bit: run = resume pulse, step = single-step pulse, step_mode = stop after each instruction.
REQ-010 SHALL have outputs sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc and data_e, each 1 bit, with the same datapath-control meanings as the existing controller.
REQ-011 SHALL have output phase, 3 bits: current phase, 0..7.
REQ-012 SHALL have output state, 2 bits: encodes RUN=0, HALTED=1, STEP_WAIT=2 or MEM_WAIT=3.
REQ-013 SHALL have output timeout_err, 1 bit: sticky memory-stall timeout flag.

Function
REQ-014 SHALL contain an internal phase counter; in RUN it advances by 1 per clock and wraps 7->0.
REQ-015 SHALL decode the opcode as follows: H = (opcode==HLT); Z = (opcode==SKZ && zero); A = ADD/AND/XOR/LDA; S = STO; J = JMP.
REQ-016 SHALL drive the controls combinationally from phase and state; any control not listed for a phase is 0, and sel is 0 in phases 4-7.
- Phase 0: sel=1.
- Phase 1: sel=1, rd=1.
- Phases 2-3: sel=1, rd=1, ld_ir=1.
- Phase 4: halt=H, inc_pc=1.
- Phase 5: rd=A.
- Phase 6: rd=A, inc_pc=Z, ld_pc=J, data_e=S.
- Phase 7: rd=A, ld_ac=A, ld_pc=J, wr=S, data_e=S.
REQ-017 SHALL define wait points as phase 3, and phase 7 when A or S is true; at a wait point with WAIT_EN=1 and mem_ready=0, the state SHALL go to MEM_WAIT.
REQ-018 SHALL, in MEM_WAIT, hold the phase and the phase's outputs, and increment the stall counter each cycle.
REQ-019 SHALL, in MEM_WAIT with mem_ready=1, return to RUN, advance the phase, and clear the stall counter.
REQ-020 SHALL, when the stall counter reaches 2^WAIT_W-1 with mem_ready still 0, set timeout_err (sticky until reset), enter HALTED, and force phase to 0.
REQ-021 SHALL, at the end of phase 4 with H=1, enter HALTED with phase 0; phase 4 keeps inc_pc=1 so the PC points past the HLT instruction.
REQ-022 SHALL, in HALTED, output halt=1 and sel=1 with all other controls 0, and hold phase at 0.
REQ-023 SHALL, in HALTED, treat a run=1 pulse as a transition to RUN, with phase 0 executing on the next cycle; step is ignored in HALTED.
REQ-024 SHALL, with STEP_EN=1 and step_mode=1 at the end of phase 7, enter STEP_WAIT with phase 0 and outputs sel=1 only.
REQ-025 SHALL, in STEP_WAIT, leave the state on step=1 or run=1 and go to RUN; if step_mode is deasserted while in STEP_WAIT, a step or run pulse is still required to leave.
REQ-026 SHALL give simultaneous events this priority: timeout > HLT > step_mode stop.
REQ-027 SHALL, when run and step are both 1 in STEP_WAIT, go to RUN once.
REQ-028 SHALL, when mem_ready=1 at a wait point, cause no stall, i.e. zero added latency.
REQ-029 SHALL take exactly 8 cycles per instruction with no stalls, and 8+N cycles with N stall cycles.

Reset
REQ-030 SHALL, on rst=1 asynchronously, set state=RUN, phase=0, stall counter=0 and timeout_err=0.
REQ-031 SHALL, during and immediately after reset, drive outputs sel=1 with all other controls 0.
REQ-032 SHALL abort any instruction, stall, halt or step wait on a reset asserted mid-operation, with no partial wr or ld pulse after rst rises.

Structure
REQ-033 SHALL place the opcode localparams and the state encoding in the shared package risc_pkg.
REQ-034 SHALL implement the phase/stall counters and FSM in this module, with decode in one sub-module risc_decode: purely combinational, taking phase, opcode, zero and state, and producing the nine control outputs.

Verification
REQ-035 SHALL cover: reset, then ADD with mem_ready=1 -> phases 0..7 in 8 cycles; ld_ac=1 only in phase 7.
REQ-036 SHALL cover: STO with mem_ready=0 for 3 cycles at phase 7 -> wr=1 and data_e=1 held 4 cycles; next phase 0 follows at cycle 11.
REQ-037 SHALL cover: HLT -> halt=1 at phase 4, then state=HALTED and halt held; run pulse -> phase 0 next cycle, halt=0.
REQ-038 SHALL cover: SKZ with zero=1 -> inc_pc=1 in phases 4 and 6; with zero=0 -> inc_pc=1 in phase 4 only.
REQ-039 SHALL cover: WAIT_W=4 and mem_ready stuck 0 at phase 3 -> timeout_err=1 after 15 stall cycles, state=HALTED; rst clears timeout_err.
REQ-040 SHALL cover: step_mode=1 with JMP -> STEP_WAIT after phase 7; step pulse -> exactly one more instruction, then STEP_WAIT again; rst asserted in phase 6 -> outputs go to sel=1 only, asynchronously.
